// File: rtl/plat_pkg.sv
// plat_pkg: state encodings and LFSR constants shared by the platform scroller.
package plat_pkg;
  typedef enum logic [1:0] {ST_STOP = 2'b00, ST_MOVE = 2'b01, ST_ELEV = 2'b10, ST_DIE = 2'b11} state_t;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 8'hA5;
endpackage

// File: rtl/plat_lfsr.sv
// plat_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), sync active-low reset, zero seed forced to 1.
module plat_lfsr import plat_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] o_lfsr
);
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;
  logic [LFSR_W-1:0] r_lfsr;
  always_ff @(posedge clk)
    if (!reset) r_lfsr <= SEED_NZ;
    else r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/platform_scroller.sv
// platform_scroller: scrolls NUM_PLAT platforms upward on a wrapping row grid at a divided step rate.
// Define PLAT_RAND_X_EN to respawn wrapped platforms at an LFSR-chosen column.
module platform_scroller import plat_pkg::*; #(
  parameter int NUM_PLAT = 3,
  parameter int Y_W = 4,
  parameter int ROWS = 12,
  parameter int FIRST_Y = 2,
  parameter int SPACING = 4,
  parameter int X_W = 3,
  parameter int STEP_DIV = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              state,
  output logic [NUM_PLAT*Y_W-1:0] plat_y,
  output logic [NUM_PLAT*X_W-1:0] plat_x,
  output logic [NUM_PLAT-1:0]     wrap,
  output logic                    step
);
  localparam int DIV_W = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(ROWS - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(STEP_DIV - 1);
  if (ROWS > 2**Y_W || STEP_DIV < 1) begin : g_bad_cfg
    $error("platform_scroller: requires ROWS <= 2**Y_W and STEP_DIV >= 1");
  end
  logic [Y_W-1:0] r_y [NUM_PLAT];
  logic [X_W-1:0] r_x [NUM_PLAT];
  logic [DIV_W-1:0] r_div;
  logic [NUM_PLAT-1:0] r_wrap;
  logic r_step;
  logic w_adv, w_fire;
  assign w_adv = state == ST_MOVE || state == ST_ELEV;
  assign w_fire = w_adv && r_div == DIV_MAX;
`ifdef PLAT_RAND_X_EN
  logic [LFSR_W-1:0] w_lfsr;
  plat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .o_lfsr(w_lfsr));
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div <= '0;
      r_step <= 1'b0;
      r_wrap <= '0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        r_y[i] <= Y_W'((FIRST_Y + i * SPACING) % ROWS);
        r_x[i] <= X_W'(i);
      end
    end else begin
      // Die flushes partial progress toward the next step; Stop only pauses it.
      r_div <= (state == ST_DIE || w_fire) ? '0 : w_adv ? r_div + DIV_W'(1) : r_div;
      r_step <= w_fire;
      for (int i = 0; i < NUM_PLAT; i++) begin
        r_wrap[i] <= w_fire && r_y[i] == Y_MAX;
        if (w_fire) r_y[i] <= r_y[i] == Y_MAX ? '0 : r_y[i] + Y_W'(1);
`ifdef PLAT_RAND_X_EN
        if (w_fire && r_y[i] == Y_MAX) r_x[i] <= w_lfsr[X_W-1:0] ^ X_W'(i);
`endif
      end
    end
  end
  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_pack
    assign plat_y[g*Y_W +: Y_W] = r_y[g];
    assign plat_x[g*X_W +: X_W] = r_x[g];
  end
  assign wrap = r_wrap;
  assign step = r_step;
endmodule

// File: doc/platform_scroller.md
# platform_scroller

Parametrised vertical platform scroller for the falling-player game datapath. Tracks `NUM_PLAT` platforms on a wrapping row grid and advances them upward while the game FSM is in Movement or Elevation, at a programmable step rate. On wrap it flags the platform and optionally respawns it at a new horizontal column. Sits between the game-state FSM and the display/collision logic.

## Interface
- `NUM_PLAT`, 3: number of platforms tracked.
- `Y_W`, 4: row coordinate width.
- `ROWS`, 12: rows in the grid. Y runs 0..ROWS-1. Must satisfy ROWS <= 2^Y_W.
- `FIRST_Y`, 2: reset row of platform 0.
- `SPACING`, 4: reset row gap between consecutive platforms.
- `X_W`, 3: column coordinate width.
- `STEP_DIV`, 1: enabled clock ticks per one-row step. Must be >= 1.
- `LFSR_SEED`, 8'hA5: LFSR reset value. A zero seed is replaced by 8'h01.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset. Asserted when 0 at a `clk` edge.
- `state`  in  2  game state: 00 Stop, 01 Movement, 10 Elevation, 11 Die.
- `plat_y`  out  NUM_PLAT*Y_W  packed rows. Platform i occupies `[i*Y_W +: Y_W]`.
- `plat_x`  out  NUM_PLAT*X_W  packed columns, same packing as `plat_y`.
- `wrap`  out  NUM_PLAT  one-cycle pulse per platform that wrapped on this step.
- `step`  out  1  one-cycle pulse when a step occurred.

## Operation
- Reset values:
  - plat_y[i] = (FIRST_Y + i*SPACING) mod ROWS.
  - plat_x[i] = i mod 2^X_W.
  - Divider = 0, LFSR = seed, `wrap` = 0, `step` = 0.
- Advance enable `adv` is true when state is 01 or 10.
- Divider:
  - While `adv` is true, the divider counts 0..STEP_DIV-1.
  - At STEP_DIV-1 the divider returns to 0 and a step fires.
  - In Stop the divider holds its value.
  - In Die the divider clears to 0.
- On a step, each platform is updated independently:
  - If y == ROWS-1: y <= 0 and wrap[i] <= 1.
  - Otherwise: y <= y+1.
  - Any number of platforms may wrap on the same step.
- `step` and `wrap` are 0 on every cycle that is not a step.
- In Stop and Die, `plat_y` and `plat_x` hold their values.
- Y arithmetic is modulo ROWS, never modulo 2^Y_W.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every non-reset cycle, regardless of `state`.

## Timing
- All outputs are registered.
- New positions, `step` and `wrap` appear on the same edge that fires the step. Latency is 1 cycle from the enabling edge.
- With STEP_DIV=1 a step fires on every enabled cycle.
- With STEP_DIV=N, the first step fires on the Nth consecutive enabled edge after reset or after Die.
- A state change takes effect on the next edge. No handshake.
- Reset mid-step overrides everything. Divider and LFSR restart, and there is no `wrap` pulse on the reset edge.

## Configuration
- `PLAT_RAND_X_EN` defined: on wrap, plat_x[i] <= lfsr[X_W-1:0] ^ i[X_W-1:0]. The LFSR value sampled is the pre-shift value on that edge. Simultaneous wraps therefore get distinct columns.
- `PLAT_RAND_X_EN` undefined:
  - `plat_x` stays at its reset value permanently.
  - The LFSR and its submodule are not instantiated.

## Structure
- Shared package `plat_pkg`:
  - State encodings ST_STOP, ST_MOVE, ST_ELEV, ST_DIE.
  - LFSR width and tap mask.
  - Default LFSR seed.
- One submodule, `plat_lfsr`: 8-bit LFSR with seed parameter, synchronous active-low reset and zero-seed guard.
- Elaboration check: fail when ROWS > 2^Y_W or STEP_DIV < 1.

## Test plan
- Defaults, reset low for 1 edge -> plat_y = {10,6,2} (platforms 2,1,0), plat_x = {2,1,0}, `step` = 0, `wrap` = 0.
- state=01 for 2 edges -> plat_y goes 3,7,11 then 4,8,0. On the 2nd edge wrap=3'b100 and step=1.
- state=00 for 5 edges after a step -> positions unchanged, `step`/`wrap` held 0. Resuming 01 steps on the next edge.
- STEP_DIV=3, state=10 for 6 edges -> steps on edges 3 and 6 only. Die in between clears the divider, so the next step needs 3 fresh enabled edges.
- ROWS=4, SPACING=0, FIRST_Y=3, NUM_PLAT=3, `PLAT_RAND_X_EN` defined, state=01 for 1 edge -> all plat_y = 0, wrap=3'b111, and the three plat_x values are pairwise distinct.
- Reset driven low mid-Movement with a wrap pending -> next edge gives reset values and wrap=0.
